// File: rtl/mul_seq_pkg.sv
// mul_pkg: shared types and constants for the repeated-addition multiplier.
//   MUL_W   : default operand / counter / product width
//   state_t : controller state encoding
package mul_pkg;

  localparam int unsigned MUL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CLRP = 2'b01,
    ADD  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/mul_seq_if.sv
// mul_seq_if: request/status and product-register signals of mul_seq.
//   start, a_in, b_in       : multiply request and operands
//   p_q                     : product register output (fed back)
//   p_din, p_ld, p_clr      : product register data / load / clear
//   busy, done, ovf         : status
// master = requester + product register side, slave = mul_seq.
interface mul_seq_if
  import mul_pkg::*;
#(
  parameter int unsigned W = MUL_W
) ();

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] p_q;
  logic [W-1:0] p_din;
  logic         p_ld;
  logic         p_clr;
  logic         busy;
  logic         done;
  logic         ovf;

  modport master (
    output start, a_in, b_in, p_q,
    input  p_din, p_ld, p_clr, busy, done, ovf
  );

  modport slave (
    input  start, a_in, b_in, p_q,
    output p_din, p_ld, p_clr, busy, done, ovf
  );

endinterface

// File: rtl/mul_seq_down_cntr.sv
// down_cntr: loadable down-counter holding the remaining repeat count.
//   clk, clr  : clock, synchronous active-high clear
//   load, din : parallel load
//   dec       : decrement by one
//   q         : count; one = (q == 1), zero = (q == 0)
// Priority: clr > load > dec.
module down_cntr
  import mul_pkg::*;
#(
  parameter int unsigned W = MUL_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         one,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (dec) begin
      q <= q - W'(1);
    end
  end

  assign one  = (q == W'(1));
  assign zero = (q == '0);

endmodule

// File: rtl/mul_seq.sv
// mul_seq: control and arithmetic front end of a repeated-addition multiplier
// driving an external W-bit product register.
//   clk   : clock, rising edge
//   clr   : synchronous active-high reset (the product register must also
//           receive it; p_clr is not asserted during clr)
//   bus   : mul_seq_if slave modport (start/a_in/b_in in, p_q feedback,
//           p_din/p_ld/p_clr to the product register, busy/done/ovf status)
// p_din is always p_q + A; the adder carry-out only sets the sticky ovf flag.
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned W = MUL_W
) (
  input  logic      clk,
  input  logic      clr,
  mul_seq_if.slave  bus
);

  state_t       state_q, state_d;
  logic [W-1:0] a_q;
  logic         ovf_q;
  logic [W:0]   sum;
  logic         cnt_load, cnt_dec;
  logic [W-1:0] cnt_q;
  logic         cnt_one, cnt_zero;

  assign cnt_load = (state_q == IDLE) && bus.start;
  assign cnt_dec  = (state_q == ADD);

  down_cntr #(
    .W (W)
  ) u_cnt (
    .clk  (clk),
    .clr  (clr),
    .load (cnt_load),
    .dec  (cnt_dec),
    .din  (bus.b_in),
    .q    (cnt_q),
    .one  (cnt_one),
    .zero (cnt_zero)
  );

  assign sum       = {1'b0, bus.p_q} + {1'b0, a_q};
  assign bus.p_din = sum[W-1:0];

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      a_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cnt_load) begin
        a_q   <= bus.a_in;
        ovf_q <= 1'b0;
      end else if (state_q == ADD && sum[W]) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bus.p_clr = 1'b0;
    bus.p_ld  = 1'b0;
    bus.done  = 1'b0;
    bus.busy  = 1'b1;
    unique case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_d = CLRP;
      end
      CLRP: begin
        bus.p_clr = 1'b1;
        state_d   = (a_q == '0 || cnt_zero) ? DONE : ADD;
      end
      ADD: begin
        bus.p_ld = 1'b1;
        // Count still shows the value before this cycle's decrement.
        if (cnt_one) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ovf = ovf_q;

  // Counter value is only consumed through one/zero.
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mul_seq_if #(.W(W)) bus ();

  mul_seq #(.W(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Product register sitting downstream of the controller.
  always @(posedge clk) begin
    if (clr || bus.p_clr) bus.p_q <= '0;
    else if (bus.p_ld)    bus.p_q <= bus.p_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One multiply from start to the IDLE cycle after done, checked against
  // plain integer arithmetic.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit repulse);
    longint unsigned full;
    int exp_lat, exp_loads, loads;
    bit seen;
    logic [W-1:0] exp_p;
    full      = longint'(a) * longint'(b);
    exp_p     = W'(full % 65536);
    exp_lat   = (a == 0 || b == 0) ? 2 : int'(b) + 2;
    exp_loads = (a == 0 || b == 0) ? 0 : int'(b);
    loads     = 0;
    seen      = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = a; bus.b_in = b;
    for (int cyc = 1; cyc <= exp_lat + 5 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.start = 1'b0;
        bus.a_in  = W'($urandom);
        bus.b_in  = W'($urandom);
        chk("pclr_c1", 32'(bus.p_clr), 32'd1);
      end
      if (repulse && (cyc == 3 || cyc == 4)) begin
        bus.start = 1'b1;
        bus.a_in  = W'(cyc * 11);
        bus.b_in  = W'(cyc + 2);
      end else if (repulse && cyc == 5) begin
        bus.start = 1'b0;
      end
      if (bus.p_ld === 1'b1) loads++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        chk("done_cycle", 32'(cyc), 32'(exp_lat));
        chk("product", 32'(bus.p_q), 32'(exp_p));
        chk("ovf", 32'(bus.ovf), (full > 65535) ? 32'd1 : 32'd0);
        chk("load_count", 32'(loads), 32'(exp_loads));
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("p_hold", 32'(bus.p_q), 32'(exp_p));
    chk("p_din_hold", 32'(bus.p_din), 32'(W'(exp_p + a)));
  endtask

  initial begin
    int dones;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_p_ld", 32'(bus.p_ld), 32'd0);
    chk("rst_p_clr", 32'(bus.p_clr), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_p_din", 32'(bus.p_din), 32'(bus.p_q));
    chk("rst_p_q", 32'(bus.p_q), 32'd0);

    // Directed cases.
    run_op(16'd17, 16'd5, 1'b0);
    run_op(16'd0, 16'd9, 1'b0);
    run_op(16'd9, 16'd0, 1'b0);
    run_op(16'd300, 16'd300, 1'b0);
    run_op(16'd2, 16'd3, 1'b0);
    run_op(16'd5, 16'd4, 1'b1);
    run_op(16'hFFFF, 16'd1, 1'b0);
    run_op(16'hFFFF, 16'd2, 1'b0);

    // Abort mid-operation: clr during cycle 4 of A=7, B=10.
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = 16'd7; bus.b_in = 16'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_p_ld", 32'(bus.p_ld), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_ovf", 32'(bus.ovf), 32'd0);
    dones = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op(16'd3, 16'd3, 1'b0);

    // Random operands, full-range A so wrap-around occurs regularly.
    for (int i = 0; i < 12; i++) begin
      run_op(W'($urandom_range(0, 65535)), W'($urandom_range(0, 40)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit in case the sequence stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Control-and-arithmetic front end of the repeated-addition multiplier, sitting directly upstream of the 16-bit product register. It captures multiplicand A and multiplier B on `start`, then drives the product register's clear, load and data inputs. While a down-counter on B runs, it presents `p_q + A` to the register once per cycle. It signals completion with a one-cycle `done` pulse and reports wrap-around through a sticky `ovf` flag.

## Interface
- `W`, default 16: operand, counter and product width.

- `clk` in 1: single clock, rising edge.
- `clr` in 1: reset. **Synchronous, active-high; the only reset.**
- `start` in 1: request a multiply. Sampled only in IDLE.
- `a_in` in W: multiplicand, captured when `start` is accepted.
- `b_in` in W: multiplier (repeat count), captured when `start` is accepted.
- `p_q` in W: product register output, fed back.
- `p_din` out W: product register data input, always `p_q + A` mod 2^W.
- `p_ld` out 1: product register load.
- `p_clr` out 1: product register clear.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `ovf` out 1: sticky carry-out of any accumulation in the current operation.

## Operation
- States:
  - **IDLE**: waits for `start`. On `start`=1: A←`a_in`, B←`b_in`, ovf←0, go to CLRP.
  - **CLRP**: `p_clr`=1. If A==0 or B==0, go to DONE; else go to ADD.
  - **ADD**: `p_ld`=1 and B←B−1. If carry-out of `p_q+A` =1, then ovf←1. If B==1, go to DONE; else stay in ADD.
  - **DONE**: `done`=1, go to IDLE.
- Outputs are Moore, decoded from state only.
- `busy`=1 in CLRP, ADD and DONE; 0 in IDLE.
- `start` is ignored whenever `busy`=1. There is no queueing, and `a_in`/`b_in` may change freely after capture.
- Arithmetic:
  - The W-bit adder's carry-out feeds only `ovf`.
  - The product wraps modulo 2^W.
  - B never underflows, because ADD is never entered with B==0.
- `clr` has priority over every other input:
  - Next state IDLE.
  - A, B and ovf cleared.
  - `p_ld`, `p_clr`, `done` and `busy` all 0 the cycle after `clr`.
- `clr` mid-operation aborts the operation with no `done` pulse.
- `mul_seq` does not assert `p_clr` during `clr`. The product register must receive the same `clr` signal at system level.

## Timing
- Reset values: state IDLE, A=0, B=0, `busy`=0, `done`=0, `p_ld`=0, `p_clr`=0, `ovf`=0. `p_din` follows `p_q`, since A=0.
- Cycle numbering: `start` sampled at the end of cycle 0.
- Cycle 1 is CLRP; the product register is zero from cycle 2.
- Cycles 2..B+1 are ADD, giving exactly B loads.
- Cycle B+2 is DONE. Here `p_q` holds A·B mod 2^W and `ovf` is final.
- Total latency from `start` to `done` is B+2 cycles.
- Zero-operand case: `done` in cycle 2 with `p_q`=0 and `ovf`=0.
- `p_q`, `ovf` and the captured A remain stable after DONE until the next accepted `start`.
- A `start` held high through DONE is accepted in the following IDLE cycle, so there is a minimum of one IDLE cycle between operations.

## Structure
- Package `mul_pkg`:
  - State encoding: IDLE=2'b00, CLRP=2'b01, ADD=2'b10, DONE=2'b11.
  - Default width constant `MUL_W`=16.
- Sub-module `down_cntr`, parameter W.
  - Ports: `clk`, `clr`, `load`, `dec`, `din`, `q`, and `one` (q==1), plus `zero` (q==0).
  - `clr` > `load` > `dec` priority.
- `mul_seq` contains the FSM, the A register, the adder and the ovf flag, and instantiates `down_cntr`.

## Test plan
- `clr` held 2 cycles, then released → all outputs 0, state IDLE, `p_din`==`p_q`.
- A=17, B=5, `start` in cycle 0 → `p_clr` in cycle 1, `p_ld` in cycles 2–6, `done` in cycle 7, `p_q`=85, `ovf`=0.
- A=0, B=9 and, separately, A=9, B=0 → `done` in cycle 2, `p_q`=0, no `p_ld` pulse.
- A=300, B=300 → `done` in cycle 302, `p_q`=24464, `ovf`=1. A following A=2, B=3 run gives `ovf`=0 and `p_q`=6.
- `start` re-pulsed in cycles 3 and 4 with different operands during A=5, B=4 → ignored, result 20.
- `clr` in cycle 4 of A=7, B=10 → IDLE in cycle 5, no `done`. A new A=3, B=3 then completes with 9.
